// File: rtl/moore_detect_sched_if.sv
// -----------------------------------------------------------------------------
// moore_detect_sched_if
//   Groups the per-channel serial source signals shared between the requesters
//   and the pattern-detector scheduler.
//
//   req      source -> sched  per-channel frame request (level)
//   bit_in   source -> sched  per-channel serial data
//   bit_vld  source -> sched  per-channel data valid
//   bit_rdy  sched  -> source per-channel ready (one-hot or zero)
//   gnt      sched  -> source one-hot grant
//
//   master : the serial sources
//   slave  : the scheduler / detector
// -----------------------------------------------------------------------------
interface moore_detect_sched_if #(
   parameter int NCH = 4
);

   logic [NCH-1:0] req;
   logic [NCH-1:0] bit_in;
   logic [NCH-1:0] bit_vld;
   logic [NCH-1:0] bit_rdy;
   logic [NCH-1:0] gnt;

   modport master (
      output req,
      output bit_in,
      output bit_vld,
      input  bit_rdy,
      input  gnt
   );

   modport slave (
      input  req,
      input  bit_in,
      input  bit_vld,
      output bit_rdy,
      output gnt
   );

endinterface

// File: rtl/moore_detect_sched.sv
// -----------------------------------------------------------------------------
// moore_detect_sched
//   One programmable serial pattern detector shared by NCH requesters. A
//   round-robin arbiter picks one channel per frame; the winner streams
//   FRAME_LEN bits over a valid/ready handshake while overlapping matches of
//   the latched pattern are counted. Completion is flagged with a done pulse,
//   a dropped request with an abort pulse.
//
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   cfg_pat    in   pattern, bit [PAT_W-1] is the first bit expected
//   sif        slave modport: req / bit_in / bit_vld in, bit_rdy / gnt out
//   busy       out  high in every state except IDLE
//   done       out  1-cycle pulse, frame completed
//   abort      out  1-cycle pulse, frame abandoned
//   done_ch    out  channel of the last granted frame
//   match_cnt  out  matches counted in the last frame
//
//   State sequence: IDLE -> GRANT -> RUN -> (DONE | ABORT) -> IDLE.
//   gnt is visible in GRANT, RUN and DONE; bit_rdy only in RUN.
// -----------------------------------------------------------------------------
module moore_detect_sched #(
   parameter int NCH       = 4,
   parameter int FRAME_LEN = 16,
   parameter int PAT_W     = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [PAT_W-1:0]               cfg_pat,
   moore_detect_sched_if.slave            sif,
   output logic                           busy,
   output logic                           done,
   output logic                           abort,
   output logic [$clog2(NCH)-1:0]         done_ch,
   output logic [$clog2(FRAME_LEN+1)-1:0] match_cnt
);

   localparam int CW = $clog2(NCH);
   localparam int MW = $clog2(FRAME_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_RUN,
      S_DONE,
      S_ABORT
   } state_t;

   state_t           state;
   state_t           state_nx;

   logic [CW-1:0]    rr_ptr;     // first channel considered in the next arbitration
   logic [CW-1:0]    gsel;       // channel owning the current frame
   logic [CW-1:0]    winner;
   logic [CW-1:0]    cand;
   logic             found;
   logic [NCH-1:0]   gsel_oh;

   logic [PAT_W-1:0] pat_q;      // pattern frozen for the whole frame
   logic [PAT_W-1:0] hist;       // most recent accepted bits, newest in bit 0
   logic [PAT_W-1:0] hist_nx;
   logic [MW-1:0]    bit_cnt;    // bits accepted so far in this frame

   logic             cur_req;
   logic             accept;
   logic             last_bit;
   logic             hit;

   // Channel index modulo NCH; NCH need not be a power of two.
   function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NCH) begin
         sum = sum - NCH;
      end
      return CW'(sum);
   endfunction

   // ---------------------------------------------------------------------------
   // Round-robin pick: first requester at or after rr_ptr, wrapping upward.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can
      // leave it unassigned and no latch is inferred.
      winner = rr_ptr;
      found  = 1'b0;
      cand   = '0;
      for (int i = 0; i < NCH; i++) begin
         cand = wrap_add(rr_ptr, i);
         if (!found && sif.req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath decode for the granted channel.
   // ---------------------------------------------------------------------------
   assign gsel_oh  = {{(NCH-1){1'b0}}, 1'b1} << gsel;
   assign cur_req  = sif.req[gsel];

   // A dropped request wins over a simultaneous valid bit: that bit is left
   // with the source and the frame is abandoned instead.
   assign accept   = (state == S_RUN) && cur_req && sif.bit_vld[gsel];

   assign hist_nx  = {hist[PAT_W-2:0], sif.bit_in[gsel]};
   assign last_bit = (bit_cnt == MW'(FRAME_LEN - 1));

   // The history only holds a full pattern once PAT_W bits have arrived,
   // counting the bit being accepted now; older bits keep overlaps countable.
   assign hit      = (hist_nx == pat_q) && (bit_cnt >= MW'(PAT_W - 1));

   // ---------------------------------------------------------------------------
   // FSM state register.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments in clocked blocks, so every register
      // updates from values sampled before the edge.
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and Moore outputs.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nx    = state;
      busy        = 1'b1;
      done        = 1'b0;
      abort       = 1'b0;
      sif.gnt     = '0;
      sif.bit_rdy = '0;

      unique case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (|sif.req) begin
               state_nx = S_GRANT;
            end
         end

         S_GRANT: begin
            sif.gnt  = gsel_oh;
            state_nx = S_RUN;
         end

         S_RUN: begin
            sif.gnt     = gsel_oh;
            sif.bit_rdy = gsel_oh;
            if (!cur_req) begin
               state_nx = S_ABORT;
            end else if (accept && last_bit) begin
               state_nx = S_DONE;
            end
         end

         S_DONE: begin
            sif.gnt  = gsel_oh;
            done     = 1'b1;
            state_nx = S_IDLE;
         end

         S_ABORT: begin
            abort    = 1'b1;
            state_nx = S_IDLE;
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Frame datapath: winner capture, pattern latch, shift history, counters.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: pattern and history registers are reset along with the counters;
      // they are plain flops, not a memory, so this costs nothing and keeps
      // them free of X after reset.
      if (!rst) begin
         rr_ptr    <= '0;
         gsel      <= '0;
         pat_q     <= '0;
         hist      <= '0;
         bit_cnt   <= '0;
         match_cnt <= '0;
         done_ch   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (|sif.req) begin
                  gsel <= winner;
               end
            end

            S_GRANT: begin
               pat_q     <= cfg_pat;
               hist      <= '0;
               bit_cnt   <= '0;
               match_cnt <= '0;
               done_ch   <= gsel;
            end

            S_RUN: begin
               if (accept) begin
                  hist    <= hist_nx;
                  bit_cnt <= bit_cnt + MW'(1);
                  if (hit) begin
                     match_cnt <= match_cnt + MW'(1);
                  end
               end
            end

            S_DONE, S_ABORT: begin
               rr_ptr <= wrap_add(gsel, 1);
            end

            default: begin
               rr_ptr <= rr_ptr;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_moore_detect_sched.sv
// -----------------------------------------------------------------------------
// tb_moore_detect_sched
//   Directed bench for moore_detect_sched. A frame-level model (winner search,
//   queue of accepted bits, pattern scan over the queue) predicts every output
//   on every falling edge; directed scenarios add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_moore_detect_sched;

   localparam int NCH       = 4;
   localparam int FRAME_LEN = 16;
   localparam int PAT_W     = 4;
   localparam int CW        = $clog2(NCH);
   localparam int MW        = $clog2(FRAME_LEN + 1);

   // model phases
   localparam int M_IDLE  = 0;
   localparam int M_GRANT = 1;
   localparam int M_RUN   = 2;
   localparam int M_DONE  = 3;
   localparam int M_ABORT = 4;

   // source valid modes
   localparam int V_OFF    = 0;
   localparam int V_ALWAYS = 1;
   localparam int V_TOGGLE = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [PAT_W-1:0] cfg_pat;
   logic             busy;
   logic             done;
   logic             abort;
   logic [CW-1:0]    done_ch;
   logic [MW-1:0]    match_cnt;

   moore_detect_sched_if #(.NCH(NCH)) sif ();

   moore_detect_sched #(
      .NCH       (NCH),
      .FRAME_LEN (FRAME_LEN),
      .PAT_W     (PAT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_pat   (cfg_pat),
      .sif       (sif),
      .busy      (busy),
      .done      (done),
      .abort     (abort),
      .done_ch   (done_ch),
      .match_cnt (match_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Frame-level reference model
   // ---------------------------------------------------------------------------
   int             m_phase   = M_IDLE;
   int             m_rr      = 0;
   int             m_ch      = 0;
   int             m_done_ch = 0;
   logic [PAT_W-1:0] m_pat   = '0;
   bit             m_bits[$];

   function automatic int count_matches(input logic [PAT_W-1:0] pat, input bit q[$]);
      int n;
      bit h;
      n = 0;
      for (int s = 0; s + PAT_W <= q.size(); s++) begin
         h = 1'b1;
         for (int k = 0; k < PAT_W; k++) begin
            if (q[s+k] != pat[PAT_W-1-k]) h = 1'b0;
         end
         if (h) n++;
      end
      return n;
   endfunction

   function automatic int pick(input logic [NCH-1:0] r, input int rr);
      for (int i = 0; i < NCH; i++) begin
         if (r[(rr + i) % NCH]) return (rr + i) % NCH;
      end
      return -1;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_phase   = M_IDLE;
         m_rr      = 0;
         m_ch      = 0;
         m_done_ch = 0;
         m_pat     = '0;
         m_bits.delete();
      end else begin
         case (m_phase)
            M_IDLE: begin
               if (|sif.req) begin
                  m_ch    = pick(sif.req, m_rr);
                  m_phase = M_GRANT;
               end
            end
            M_GRANT: begin
               m_pat     = cfg_pat;
               m_bits.delete();
               m_done_ch = m_ch;
               m_phase   = M_RUN;
            end
            M_RUN: begin
               if (!sif.req[m_ch]) begin
                  m_phase = M_ABORT;
               end else if (sif.bit_vld[m_ch]) begin
                  m_bits.push_back(sif.bit_in[m_ch]);
                  if (m_bits.size() == FRAME_LEN) m_phase = M_DONE;
               end
            end
            default: begin
               m_rr    = (m_ch + 1) % NCH;
               m_phase = M_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Per-cycle compare plus event logging (falling edge)
   // ---------------------------------------------------------------------------
   int             grant_log[$];
   int             n_done      = 0;
   int             rdy2_cycles = 0;
   logic [NCH-1:0] prev_gnt    = '0;

   initial forever begin
      logic [NCH-1:0] e_gnt;
      logic [NCH-1:0] e_rdy;
      @(negedge clk);
      e_gnt = '0;
      e_rdy = '0;
      if (m_phase == M_GRANT || m_phase == M_RUN || m_phase == M_DONE) e_gnt[m_ch] = 1'b1;
      if (m_phase == M_RUN) e_rdy[m_ch] = 1'b1;
      check("busy",      busy,        (m_phase != M_IDLE));
      check("gnt",       sif.gnt,     e_gnt);
      check("bit_rdy",   sif.bit_rdy, e_rdy);
      check("done",      done,        (m_phase == M_DONE));
      check("abort",     abort,       (m_phase == M_ABORT));
      check("done_ch",   done_ch,     m_done_ch);
      check("match_cnt", match_cnt,   count_matches(m_pat, m_bits));
      check("gnt_onehot0", $onehot0(sif.gnt), 1);

      if (sif.gnt != '0 && prev_gnt == '0) begin
         for (int c = 0; c < NCH; c++) if (sif.gnt[c]) grant_log.push_back(c);
      end
      prev_gnt = sif.gnt;
      if (done) n_done++;
      if (sif.bit_rdy[2]) rdy2_cycles++;
   end

   // ---------------------------------------------------------------------------
   // Serial sources: one pattern word per channel, advanced on handshake
   // ---------------------------------------------------------------------------
   logic [FRAME_LEN-1:0] src_data [NCH];
   int                   src_idx  [NCH];
   int                   src_mode [NCH];
   bit                   src_tog  [NCH];
   bit                   acc      [NCH];

   initial begin
      for (int c = 0; c < NCH; c++) begin
         src_data[c] = '0;
         src_idx[c]  = 0;
         src_mode[c] = V_OFF;
         src_tog[c]  = 1'b0;
         acc[c]      = 1'b0;
      end
   end

   initial forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) acc[c] = sif.bit_vld[c] & sif.bit_rdy[c];
      @(posedge clk);
      #2;
      for (int c = 0; c < NCH; c++) begin
         if (acc[c]) src_idx[c]++;
         case (src_mode[c])
            V_ALWAYS: sif.bit_vld[c] = 1'b1;
            V_TOGGLE: begin
               sif.bit_vld[c] = src_tog[c];
               src_tog[c]     = ~src_tog[c];
            end
            default:  sif.bit_vld[c] = 1'b0;
         endcase
         sif.bit_in[c] = src_data[c][FRAME_LEN - 1 - (src_idx[c] % FRAME_LEN)];
      end
   end

   task automatic start_src(input int ch, input logic [FRAME_LEN-1:0] data, input int mode);
      src_data[ch] = data;
      src_idx[ch]  = 0;
      src_mode[ch] = mode;
      src_tog[ch]  = 1'b0;
   endtask

   task automatic stop_all();
      for (int c = 0; c < NCH; c++) src_mode[c] = V_OFF;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      sif.req = '0;
      stop_all();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // kind: 1 = done, 2 = abort, 0 = bound expired
   task automatic wait_end(input int bound, output int kind);
      kind = 0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (done) begin
            kind = 1;
            break;
         end
         if (abort) begin
            kind = 2;
            break;
         end
      end
   endtask

   task automatic wait_idx(input int ch, input int n);
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #3;
         if (src_idx[ch] >= n) break;
      end
      check("src_progress", (src_idx[ch] >= n), 1);
   endtask

   // ---------------------------------------------------------------------------
   // Directed scenarios
   // ---------------------------------------------------------------------------
   initial begin
      int kind;
      int t0;
      int n_done_snap;
      int exp_order [5];

      sif.req     = '0;
      sif.bit_in  = '0;
      sif.bit_vld = '0;
      cfg_pat     = '0;
      exp_order   = '{0, 1, 2, 3, 0};

      repeat (2) tick();
      rst = 1'b1;

      // reset state
      @(negedge clk);
      check("rst_busy",  busy,        0);
      check("rst_gnt",   sif.gnt,     0);
      check("rst_rdy",   sif.bit_rdy, 0);
      check("rst_match", match_cnt,   0);
      check("rst_dch",   done_ch,     0);

      // 1: ch0 frame 1011_0110_1101_1011 against 1011; matches start at bit
      //    positions 0, 3, 6, 9 and 12 -> 5 overlapping matches
      tick();
      cfg_pat = 4'b1011;
      start_src(0, 16'hB6DB, V_ALWAYS);
      sif.req = 4'b0001;
      t0      = cyc;
      @(negedge clk);
      check("t1_gnt_c0", sif.gnt, 4'b0000);
      @(negedge clk);
      check("t1_gnt_c1", sif.gnt, 4'b0001);
      check("t1_rdy_c1", sif.bit_rdy, 4'b0000);
      @(negedge clk);
      check("t1_rdy_c2", sif.bit_rdy, 4'b0001);
      wait_end(40, kind);
      check("t1_kind",    kind,      1);
      check("t1_latency", cyc - t0,  18);
      check("t1_match",   match_cnt, 5);
      check("t1_dch",     done_ch,   0);
      tick();
      sif.req = '0;
      stop_all();

      // 2: all channels requesting -> 0,1,2,3,0
      do_reset();
      grant_log.delete();
      start_src(0, 16'h1234, V_ALWAYS);
      start_src(1, 16'hBBBB, V_ALWAYS);
      start_src(2, 16'hF00D, V_ALWAYS);
      start_src(3, 16'h5A5A, V_ALWAYS);
      sif.req = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         wait_end(40, kind);
         check("t2_kind", kind, 1);
      end
      tick();
      sif.req = '0;
      stop_all();
      check("t2_ngrants", grant_log.size(), 5);
      for (int f = 0; f < 5 && f < grant_log.size(); f++) begin
         check("t2_order", grant_log[f], exp_order[f]);
      end

      // 3: ch2 valid toggling, first RUN cycle has vld=0 -> 32 RUN cycles;
      //    0110_1100_1001_1010 against 0110 -> matches at 0, 3, 10
      do_reset();
      cfg_pat = 4'b0110;
      start_src(2, 16'h6C9A, V_TOGGLE);
      sif.req     = 4'b0100;
      rdy2_cycles = 0;
      wait_end(80, kind);
      check("t3_kind",  kind,        1);
      check("t3_runs",  rdy2_cycles, 32);
      check("t3_match", match_cnt,   3);
      check("t3_dch",   done_ch,     2);
      tick();
      sif.req = '0;
      stop_all();

      // 4: ch1 drops req after 5 bits (1,0,1,1,0 -> 1 match), ch2 waiting
      do_reset();
      cfg_pat = 4'b1011;
      start_src(1, 16'hB5A0, V_ALWAYS);
      start_src(2, 16'h0F0F, V_ALWAYS);
      sif.req     = 4'b0110;
      n_done_snap = n_done;
      wait_idx(1, 5);
      sif.req = 4'b0100;
      wait_end(10, kind);
      check("t4_kind",   kind,      2);
      check("t4_dch",    done_ch,   1);
      check("t4_match",  match_cnt, 1);
      check("t4_nodone", n_done,    n_done_snap);
      wait_end(40, kind);
      check("t4_kind2",  kind,      1);
      check("t4_dch2",   done_ch,   2);
      check("t4_next",   grant_log[grant_log.size()-1], 2);
      tick();
      sif.req = '0;
      stop_all();

      // 5: reset in the middle of a ch1 frame (all-ones vs 1111: 3 after 6 bits)
      tick();
      cfg_pat = 4'b1111;
      start_src(1, 16'hFFFF, V_ALWAYS);
      sif.req = 4'b0010;
      wait_idx(1, 6);
      check("t5_pre_match", match_cnt, 3);
      rst = 1'b0;
      #1;
      check("t5_gnt",   sif.gnt,     0);
      check("t5_rdy",   sif.bit_rdy, 0);
      check("t5_match", match_cnt,   0);
      check("t5_busy",  busy,        0);
      tick();
      sif.req = '0;
      stop_all();
      tick();
      rst = 1'b1;
      for (int c = 0; c < NCH; c++) start_src(c, 16'hA5C3, V_ALWAYS);
      sif.req = 4'b1111;
      wait_end(40, kind);
      check("t5_kind",  kind,    1);
      check("t5_first", grant_log[grant_log.size()-1], 0);
      check("t5_dch",   done_ch, 0);
      tick();
      sif.req = '0;
      stop_all();

      // 6: pattern changed mid-RUN; count stays with 1011 (5), not 0110 (4)
      tick();
      cfg_pat = 4'b1011;
      start_src(3, 16'hB6DB, V_ALWAYS);
      sif.req = 4'b1000;
      repeat (4) tick();
      cfg_pat = 4'b0110;
      wait_end(40, kind);
      check("t6_kind",  kind,      1);
      check("t6_match", match_cnt, 5);
      check("t6_dch",   done_ch,   3);
      tick();
      sif.req = '0;
      stop_all();

      // no request: block stays idle
      repeat (3) begin
         @(negedge clk);
         check("idle_busy", busy, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
